// File: rtl/ws2812b_chain_capture.sv
// WS2812B chain member: skips SKIP upstream pixels, captures NUM_PIXELS pixels, forwards the rest on dout.
// Optional macro WS2812B_DOUBLE_BUFFER_EN adds a front buffer that is updated only when a frame completes.
module ws2812b_chain_capture #(
    parameter int NUM_PIXELS      = 4,
    parameter int BYTES_PER_PIXEL = 3,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int unsigned CAP_BYTES = NUM_PIXELS * BYTES_PER_PIXEL;
    localparam int unsigned IDX_W     = (CAP_BYTES > 1) ? $clog2(CAP_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CAP_BYTES - 1);
    localparam logic [10:0]      BPP_W    = 11'(BYTES_PER_PIXEL);

    localparam logic [1:0] ST_SKIP    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_PASS    = 2'd2;

    logic [CNT_W-1:0] threshold, idle_ticks;
    logic [15:0]      sh_thr, sh_idle;
    logic [2:0]       din_sel;
    logic [7:0]       skip_reg, skip_act;
    logic [IDX_W-1:0] rd_index;

    logic             din, din_q, rise, fall;
    logic [CNT_W-1:0] hi_cnt, lo_cnt;
    logic             idle, idle_q, frame_end;
    logic             bit_valid, bit_val, byte_valid;
    logic [2:0]       bit_cnt;
    logic [6:0]       shift;
    logic [7:0]       new_byte;

    logic [1:0]       state;
    logic [10:0]      byte_cnt, skip_total;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_we, cap_done;
    logic             frame_ready, pass_seen, clr_flags;
    logic [7:0]       cap_buf [CAP_BYTES];
    logic [7:0]       rd_byte;

    assign din       = ui_in[din_sel];
    assign rise      = din & ~din_q;
    assign fall      = ~din & din_q;
    assign idle      = (lo_cnt >= idle_ticks);
    assign frame_end = idle & ~idle_q;
    assign bit_valid = fall;
    assign bit_val   = (hi_cnt > threshold);
    // frame_end has priority: a byte completing on the idle edge is dropped
    assign byte_valid = bit_valid & (bit_cnt == 3'd7) & ~frame_end;
    assign new_byte   = {shift, bit_val};
    assign skip_total = {3'b000, skip_act} * BPP_W;
    assign cap_we     = (state == ST_CAPTURE) & byte_valid;
    assign cap_done   = cap_we & (cap_idx == LAST_IDX);
    assign clr_flags  = data_write & (address == 4'h3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q   <= 1'b0;
            hi_cnt  <= '0;
            lo_cnt  <= '0;
            idle_q  <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            din_q  <= din;
            idle_q <= idle;
            if (rise)
                hi_cnt <= '0;
            else if (din_q && hi_cnt != '1)
                hi_cnt <= hi_cnt + 1'b1;
            if (din_q)
                lo_cnt <= '0;
            else if (lo_cnt != '1)
                lo_cnt <= lo_cnt + 1'b1;
            if (frame_end) begin
                bit_cnt <= '0;
                shift   <= '0;
            end else if (bit_valid) begin
                bit_cnt <= bit_cnt + 1'b1;
                shift   <= new_byte[6:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CAPTURE;
            skip_act <= '0;
            byte_cnt <= '0;
            cap_idx  <= '0;
        end else if (frame_end) begin
            state    <= (skip_reg != 8'd0) ? ST_SKIP : ST_CAPTURE;
            skip_act <= skip_reg;
            byte_cnt <= '0;
            cap_idx  <= '0;
        end else begin
            case (state)
                ST_SKIP: if (byte_valid) begin
                    if (byte_cnt == skip_total - 11'd1) begin
                        state   <= ST_CAPTURE;
                        cap_idx <= '0;
                    end else begin
                        byte_cnt <= byte_cnt + 11'd1;
                    end
                end
                ST_CAPTURE: if (byte_valid) begin
                    if (cap_idx == LAST_IDX)
                        state <= ST_PASS;
                    else
                        cap_idx <= cap_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ready <= 1'b0;
            pass_seen   <= 1'b0;
        end else begin
            if (cap_done)
                frame_ready <= 1'b1;
            else if (clr_flags)
                frame_ready <= 1'b0;
            if (state == ST_PASS && bit_valid)
                pass_seen <= 1'b1;
            else if (clr_flags)
                pass_seen <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CAP_BYTES; i++)
                cap_buf[i] <= '0;
        end else if (cap_we) begin
            cap_buf[cap_idx] <= new_byte;
        end
    end

`ifdef WS2812B_DOUBLE_BUFFER_EN
    logic [7:0] front_buf [CAP_BYTES];

    // The last byte is merged in directly since it lands in cap_buf on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CAP_BYTES; i++)
                front_buf[i] <= '0;
        end else if (cap_done) begin
            for (int unsigned i = 0; i < CAP_BYTES; i++)
                front_buf[i] <= (IDX_W'(i) == cap_idx) ? new_byte : cap_buf[i];
        end
    end

    assign rd_byte = front_buf[rd_index];
`else
    assign rd_byte = cap_buf[rd_index];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            threshold  <= CNT_W'(38);
            idle_ticks <= CNT_W'(3840);
            sh_thr     <= 16'd38;
            sh_idle    <= 16'd3840;
            din_sel    <= 3'd1;
            skip_reg   <= '0;
            rd_index   <= '0;
        end else if (data_write) begin
            case (address)
                4'h0: rd_index      <= IDX_W'(32'(data_in) % CAP_BYTES);
                4'h4: sh_thr[7:0]   <= data_in;
                4'h5: sh_thr[15:8]  <= data_in;
                4'h6: sh_idle[7:0]  <= data_in;
                4'h7: sh_idle[15:8] <= data_in;
                4'h8: begin
                    threshold  <= CNT_W'(sh_thr);
                    idle_ticks <= CNT_W'(sh_idle);
                end
                4'h9: skip_reg <= data_in;
                4'hE: din_sel  <= data_in[2:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            4'h1: data_out = rd_byte;
            4'h2: data_out = {4'b0000, state, pass_seen, frame_ready};
            default: ;
        endcase
    end

    assign uo_out = {8{(state == ST_PASS) & din_q}};

endmodule

// File: tb/tb_ws2812b_chain_capture.sv
// Directed bench for ws2812b_chain_capture: frame capture, skip/forward, threshold commit, idle and reset cases.
module tb_ws2812b_chain_capture;

    localparam int H0 = 26;
    localparam int H1 = 51;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = '0;
    logic [7:0] uo_out;
    logic [3:0] address = '0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_pass   = 0;
    int bit_period = 80;
    int dout_hi  = 0;
    int dout_bad = 0;

    ws2812b_chain_capture #(
        .NUM_PIXELS(4),
        .BYTES_PER_PIXEL(3),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ui_in(ui_in),
        .uo_out(uo_out),
        .address(address),
        .data_write(data_write),
        .data_in(data_in),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (uo_out == 8'hFF)
            dout_hi++;
        else if (uo_out != 8'h00)
            dout_bad++;
    end

    task automatic send_bit(input logic b);
        int h;
        h = b ? H1 : H0;
        ui_in[1] = 1'b1;
        repeat (h) @(negedge clk);
        ui_in[1] = 1'b0;
        repeat (bit_period - h) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle_gap();
        ui_in[1] = 1'b0;
        repeat (4000) @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic read_buf(input int idx, output logic [7:0] d);
        bus_write(4'h0, 8'(idx));
        read_reg(4'h1, d);
    endtask

    function automatic int byte_hi(input logic [7:0] v);
        int ones;
        ones = $countones(v);
        return ones * H1 + (8 - ones) * H0;
    endfunction

    function automatic logic [7:0] t2_byte(input int i);
        return 8'(i * 37 + 5);
    endfunction

    task automatic test_reset();
        logic [7:0] d;
        repeat (3) @(negedge clk);
        read_reg(4'h2, d);
        n_checks++;
        if (d !== 8'h04) $display("FAIL reset_status got=%h exp=04", d); else n_pass++;
        n_checks++;
        if (uo_out !== 8'h00) $display("FAIL reset_uo_out got=%h exp=00", uo_out); else n_pass++;
        read_reg(4'h1, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL reset_buf0 got=%h exp=00", d); else n_pass++;
        read_reg(4'hF, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL unmapped_read got=%h exp=00", d); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_default_capture();
        logic [7:0] d;
        int hi0, bad0;
        hi0 = dout_hi;
        bad0 = dout_bad;
        bit_period = 80;
        for (int i = 0; i < 12; i++) send_byte(8'(8'h11 + i));
        idle_gap();
        for (int i = 0; i < 12; i++) begin
            read_buf(i, d);
            n_checks++;
            if (d !== 8'(8'h11 + i)) $display("FAIL cap_buf%0d got=%h exp=%h", i, d, 8'(8'h11 + i));
            else n_pass++;
        end
        read_reg(4'h2, d);
        n_checks++;
        if (d !== 8'h05) $display("FAIL cap_status got=%h exp=05", d); else n_pass++;
        n_checks++;
        if ((dout_hi - hi0) != 0 || (dout_bad - bad0) != 0)
            $display("FAIL cap_dout_quiet hi=%0d bad=%0d exp=0", dout_hi - hi0, dout_bad - bad0);
        else n_pass++;
        read_buf(12, d);
        n_checks++;
        if (d !== 8'h11) $display("FAIL rd_index_wrap12 got=%h exp=11", d); else n_pass++;
        read_buf(23, d);
        n_checks++;
        if (d !== 8'h1C) $display("FAIL rd_index_wrap23 got=%h exp=1c", d); else n_pass++;
    endtask

    task automatic test_threshold_commit();
        logic [7:0] d;
        bit_period = 60;
        bus_write(4'h3, 8'h00);
        bus_write(4'h4, 8'h50);
        bus_write(4'h5, 8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'hFF);
        bus_write(4'h8, 8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'hFF);
        idle_gap();
        read_buf(0, d);
        n_checks++;
        if (d !== 8'hFF) $display("FAIL thr_precommit_b0 got=%h exp=ff", d); else n_pass++;
        read_buf(5, d);
        n_checks++;
        if (d !== 8'hFF) $display("FAIL thr_precommit_b5 got=%h exp=ff", d); else n_pass++;
        read_buf(6, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL thr_postcommit_b6 got=%h exp=00", d); else n_pass++;
        read_buf(11, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL thr_postcommit_b11 got=%h exp=00", d); else n_pass++;
        bus_write(4'h4, 8'd38);
        bus_write(4'h8, 8'h00);
    endtask

    task automatic test_partial_frame();
        logic [7:0] d;
        bit_period = 60;
        bus_write(4'h3, 8'h00);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'hC3);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        idle_gap();
        read_reg(4'h2, d);
        n_checks++;
        if (d !== 8'h04) $display("FAIL partial_status got=%h exp=04", d); else n_pass++;
        for (int i = 0; i < 12; i++) send_byte(8'(8'h30 + i));
        idle_gap();
        read_buf(0, d);
        n_checks++;
        if (d !== 8'h30) $display("FAIL partial_new_b0 got=%h exp=30", d); else n_pass++;
        read_buf(3, d);
        n_checks++;
        if (d !== 8'h33) $display("FAIL partial_new_b3 got=%h exp=33", d); else n_pass++;
        read_buf(11, d);
        n_checks++;
        if (d !== 8'h3B) $display("FAIL partial_new_b11 got=%h exp=3b", d); else n_pass++;
        read_reg(4'h2, d);
        n_checks++;
        if (d !== 8'h05) $display("FAIL partial_new_status got=%h exp=05", d); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        bit_period = 60;
        bus_write(4'h3, 8'h00);
        for (int i = 0; i < 11; i++) send_byte(8'(8'h60 + i));
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        // final bit: the clear strobe lands on the falling edge that completes byte 12
        ui_in[1] = 1'b1;
        repeat (H0) @(negedge clk);
        ui_in[1] = 1'b0;
        address = 4'h3;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
        repeat (bit_period - H0 - 1) @(negedge clk);
        read_reg(4'h2, d);
        n_checks++;
        if (d !== 8'h09) $display("FAIL clr_vs_set_status got=%h exp=09", d); else n_pass++;
        bus_write(4'h3, 8'h00);
        read_reg(4'h2, d);
        n_checks++;
        if (d !== 8'h08) $display("FAIL clr_alone_status got=%h exp=08", d); else n_pass++;
        bus_write(4'h9, 8'd2);
        idle_gap();
    endtask

    task automatic test_skip_forward();
        logic [7:0] d;
        int hi0, bad0, exp_hi;
        bit_period = 60;
        read_reg(4'h2, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL skip_start_status got=%h exp=00", d); else n_pass++;
        exp_hi = 0;
        for (int i = 18; i < 36; i++) exp_hi += byte_hi(t2_byte(i));
        hi0 = dout_hi;
        bad0 = dout_bad;
        for (int i = 0; i < 36; i++) send_byte(t2_byte(i));
        bus_write(4'h9, 8'd0);
        idle_gap();
        n_checks++;
        if ((dout_hi - hi0) != exp_hi) $display("FAIL skip_dout_hi got=%0d exp=%0d", dout_hi - hi0, exp_hi);
        else n_pass++;
        n_checks++;
        if ((dout_bad - bad0) != 0) $display("FAIL skip_dout_replication got=%0d exp=0", dout_bad - bad0);
        else n_pass++;
        read_buf(0, d);
        n_checks++;
        if (d !== t2_byte(6)) $display("FAIL skip_buf0 got=%h exp=%h", d, t2_byte(6)); else n_pass++;
        read_buf(5, d);
        n_checks++;
        if (d !== t2_byte(11)) $display("FAIL skip_buf5 got=%h exp=%h", d, t2_byte(11)); else n_pass++;
        read_buf(11, d);
        n_checks++;
        if (d !== t2_byte(17)) $display("FAIL skip_buf11 got=%h exp=%h", d, t2_byte(17)); else n_pass++;
        read_reg(4'h2, d);
        n_checks++;
        if (d !== 8'h07) $display("FAIL skip_end_status got=%h exp=07", d); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        bit_period = 60;
        bus_write(4'h3, 8'h00);
        send_byte(8'h9C);
        send_byte(8'h3E);
        address = 4'h2;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 8'h04) $display("FAIL rst_capture_status got=%h exp=04", data_out); else n_pass++;
        n_checks++;
        if (uo_out !== 8'h00) $display("FAIL rst_capture_uo_out got=%h exp=00", uo_out); else n_pass++;
        read_reg(4'h1, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL rst_capture_buf0 got=%h exp=00", d); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) send_byte(8'(8'h40 + i));
        ui_in[1] = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (uo_out !== 8'hFF) $display("FAIL pass_mirror_uo_out got=%h exp=ff", uo_out); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (uo_out !== 8'h00) $display("FAIL rst_pass_uo_out got=%h exp=00", uo_out); else n_pass++;
        read_reg(4'h2, d);
        n_checks++;
        if (d !== 8'h04) $display("FAIL rst_pass_status got=%h exp=04", d); else n_pass++;
        ui_in[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_default_capture();
        test_threshold_commit();
        test_partial_frame();
        test_back_to_back();
        test_skip_forward();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ws2812b_chain_capture.md
Name: ws2812b_chain_capture

Overview:
- Parametrised successor to the single-LED WS2812B impostor TinyQV peripheral.
- Emulates position K of a WS2812B chain: skips the first SKIP pixels (upstream LEDs) and captures the next NUM_PIXELS pixels of BYTES_PER_PIXEL bytes each (3 = GRB, 4 = GRBW).
- Forwards the rest of the frame on dout, as a real chain member does.
- Captured bytes are read through an indexed window on the standard 4-bit peripheral bus.

Parameters:
- NUM_PIXELS, 4: pixels captured per frame (1..16).
- BYTES_PER_PIXEL, 3: 3 = GRB, 4 = GRBW; byte order is wire order.
- CNT_W, 16: width of the threshold/idle counters and their registers.

Ports:
- clk  in  1  peripheral clock (64 MHz nominal)
- rst_n  in  1  reset, asynchronous, active-low
- ui_in  in  8  input PMOD; DIN is selected from it
- uo_out  out  8  dout replicated on all 8 bits
- address  in  4  register address
- data_write  in  1  write strobe
- data_in  in  8  write data
- data_out  out  8  read data, combinational from address

Behaviour:
- Reset: every register is cleared asynchronously when rst_n is low. Reset values:
  - threshold = 38, idle_ticks = 3840 (active and shadow copies)
  - din_sel = 1, skip = 0, rd_index = 0
  - state = SKIP_OR_CAP (resolves to CAPTURE, since skip = 0)
  - frame_ready = 0, pass_seen = 0, buffer = 0
  - uo_out = 0x00
- DIN input:
  - din = ui_in[din_sel], registered once into din_q.
  - Rising edge: din & ~din_q. Falling edge: ~din & din_q.
- Pulse decoder:
  - hi_cnt clears on a rising edge, increments while din_q is high, and saturates at all-ones.
  - On a falling edge, bit_valid pulses for 1 cycle with bit = (hi_cnt > threshold).
- Byte assembler:
  - Shifts bits in MSB-first; byte_valid pulses on the same cycle as the 8th bit.
  - A partial byte is discarded when idle is detected.
- Idle detector:
  - lo_cnt increments while din_q is low, clears when din_q is high, and saturates.
  - idle is a level, high while lo_cnt >= idle_ticks.
  - The rising edge of idle is frame_end. frame_end resets the byte counter, the bit counter and the state.
- FSM states: SKIP, CAPTURE, PASS. On frame_end the FSM enters SKIP if skip != 0, else CAPTURE.
  - SKIP: counts byte_valid. After skip*BYTES_PER_PIXEL bytes it moves to CAPTURE. dout = 0.
  - CAPTURE: each byte_valid writes buf[cap_idx] and increments cap_idx. After NUM_PIXELS*BYTES_PER_PIXEL bytes it sets frame_ready and moves to PASS. dout = 0.
  - PASS: dout = din_q. Any bit_valid sets pass_seen. The FSM stays in PASS until frame_end.
  - The PASS transition always occurs on a falling-edge-derived byte_valid, so dout never emits a truncated high pulse.
- Register map:
  - 0x0 W: rd_index. The value wraps modulo NUM_PIXELS*BYTES_PER_PIXEL.
  - 0x1 R: buf[rd_index].
  - 0x2 R: status = {4'b0, state[1:0], pass_seen, frame_ready}, with SKIP = 0, CAPTURE = 1, PASS = 2.
  - 0x3 W: clears frame_ready and pass_seen.
  - 0x4/0x5 W: shadow threshold, low/high byte.
  - 0x6/0x7 W: shadow idle_ticks, low/high byte.
  - 0x8 W: commit. The active threshold and idle_ticks take the shadow values on the next cycle.
  - 0x9 W: skip. Takes effect at the next frame_end.
  - 0xE W: din_sel = data_in[2:0].
  - Unmapped addresses read 0x00; writes to them are ignored.
- Simultaneous events:
  - A clear (0x3 write) in the same cycle as a frame_ready set: the set wins.
  - frame_end in the same cycle as byte_valid: frame_end wins and the byte is dropped.
- frame_ready is not cleared by idle. It persists until a 0x3 write or reset.

Optional Feature:
- Macro: WS2812B_DOUBLE_BUFFER_EN.
- Defined:
  - CAPTURE writes a back buffer.
  - On the CAPTURE->PASS transition the back buffer is copied in one cycle to the front buffer, which 0x1 reads.
  - Reads are therefore always of a complete frame.
- Undefined:
  - There is a single buffer; 0x1 reads live data, which may be mid-frame.
  - Approximately NUM_PIXELS*BYTES_PER_PIXEL*8 flops are saved.

Test Plan:
1. Defaults (skip = 0, NUM_PIXELS = 4, BPP = 3). Send 12 bytes 0x11..0x1C on ui_in[1] using bit0 = 26 cycles high and bit1 = 51 cycles high (1.25 us period), then 4000 cycles low. Required: buf[0..11] = 0x11..0x1C, status = 0x05, uo_out = 0x00 throughout.
2. skip = 2, with a 36-byte frame. Required: bytes 6..17 captured; uo_out mirrors din only for bytes 18..35; status bit1 = 1.
3. Write 0x4 = 0x50, 0x5 = 0x00, then 0x8. Resend a bit with 51 cycles high. Required: decoded as 0 (threshold 80); before the commit write it decodes as 1.
4. Stop after 5 bits of byte 3 and idle 4000 cycles, then send a fresh 12-byte frame. Required: partial byte discarded; buffer holds the new frame starting at index 0.
5. Write 0x3 in the same cycle as the 12th byte_valid. Required: frame_ready = 1. Then write 0x3 alone. Required: status = 0x08 (PASS).
6. Assert rst_n = 0 mid-CAPTURE without a clock edge. Required: status = 0x04 and uo_out = 0x00 immediately. With the macro defined, front-buffer reads before any completed frame return 0x00.
